univ_shift_reg_ext: RTL and testbench

- Parametrised successor to the team's 4-bit universal shift register.
- Generalised to N bits with a multi-bit shift amount, rotate and arithmetic modes, a serial input, and a self-timed SERIALIZE mode.
- SERIALIZE streams a loaded word out LSB-first while shifting the serial input in.
- Sits between parallel datapath registers and bit-serial links (UART/SPI-style front ends).

---
 rtl/usr_pkg.sv | 20 ++
 rtl/usr_barrel_shifter.sv | 39 +++
 rtl/univ_shift_reg_ext.sv | 98 +++++++++
 tb/tb_univ_shift_reg_ext.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/usr_pkg.sv
// Shared opcode and FSM state types for the universal shift register.
package usr_pkg;

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_SHL  = 3'd1,
        OP_SHR  = 3'd2,
        OP_LOAD = 3'd3,
        OP_ROTL = 3'd4,
        OP_ROTR = 3'd5,
        OP_ASR  = 3'd6,
        OP_SER  = 3'd7
    } usr_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SER  = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_barrel_shifter.sv
// Combinational shift/rotate datapath; ops other than shifts/rotates pass q through.
module usr_barrel_shifter
    import usr_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic [N-1:0]  q,
    input  logic [AW-1:0] amt,
    input  usr_op_e       op,
    input  logic          sin,
    output logic [N-1:0]  q_next
);

    logic [2*N-1:0] shl_w;
    logic [2*N-1:0] shr_w;
    logic [2*N-1:0] asr_w;
    logic [2*N-1:0] rol_w;
    logic [2*N-1:0] ror_w;

    // Double-width trick: the companion half supplies the fill bits or the rotated-in bits.
    always_comb begin
        shl_w  = {q, {N{sin}}} << amt;
        shr_w  = {{N{sin}}, q} >> amt;
        asr_w  = {{N{q[N-1]}}, q} >> amt;
        rol_w  = {q, q} << amt;
        ror_w  = {q, q} >> amt;
        q_next = q;
        case (op)
            OP_SHL:  q_next = shl_w[2*N-1:N];
            OP_SHR:  q_next = shr_w[N-1:0];
            OP_ROTL: q_next = rol_w[2*N-1:N];
            OP_ROTR: q_next = ror_w[N-1:0];
            OP_ASR:  q_next = asr_w[N-1:0];
            default: q_next = q;
        endcase
    end

endmodule

// File: rtl/univ_shift_reg_ext.sv
// N-bit universal shift register with a self-timed LSB-first serializer mode.
module univ_shift_reg_ext
    import usr_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic [2:0]    ctrl,
    input  logic [AW-1:0] amt,
    input  logic [N-1:0]  d,
    input  logic          sin,
    output logic [N-1:0]  q,
    output logic          sout,
    output logic          sout_valid,
    output logic          busy,
    output logic          done
);

    usr_state_e    state;
    usr_state_e    state_next;
    logic [AW-1:0] cnt;
    logic [AW-1:0] cnt_next;
    logic [N-1:0]  q_next;
    logic [N-1:0]  shift_q;
    logic          done_next;
    usr_op_e       op;

    assign op = usr_op_e'(ctrl);

    usr_barrel_shifter #(
        .N (N)
    ) u_shifter (
        .q      (q),
        .amt    (amt),
        .op     (op),
        .sin    (sin),
        .q_next (shift_q)
    );

    // Next-state logic: commands decoded only in IDLE, SER shifts right until cnt hits N-1.
    always_comb begin
        state_next = state;
        q_next     = q;
        cnt_next   = cnt;
        done_next  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) begin
                    case (op)
                        OP_HOLD: q_next = q;
                        OP_LOAD: q_next = d;
                        OP_SER: begin
                            q_next     = d;
                            cnt_next   = '0;
                            state_next = ST_SER;
                        end
                        default: q_next = shift_q;
                    endcase
                end
            end
            ST_SER: begin
                q_next   = {sin, q[N-1:1]};
                cnt_next = cnt + AW'(1);
                if (cnt == AW'(N - 1)) begin
                    state_next = ST_IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State, data, counter and done-pulse registers; reset aborts any stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
            q     <= '0;
            cnt   <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            q     <= q_next;
            cnt   <= cnt_next;
            done  <= done_next;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        sout       = q[0];
        busy       = (state == ST_SER);
        sout_valid = busy;
    end

endmodule

// File: tb/tb_univ_shift_reg_ext.sv
// Directed self-checking bench for univ_shift_reg_ext at N = 8.
module tb_univ_shift_reg_ext;

    localparam int unsigned N  = 8;
    localparam int unsigned AW = 3;

    localparam logic [2:0] HOLD = 3'd0;
    localparam logic [2:0] SHL  = 3'd1;
    localparam logic [2:0] SHR  = 3'd2;
    localparam logic [2:0] LOAD = 3'd3;
    localparam logic [2:0] ROTL = 3'd4;
    localparam logic [2:0] ROTR = 3'd5;
    localparam logic [2:0] ASR  = 3'd6;
    localparam logic [2:0] SER  = 3'd7;

    logic          clk;
    logic          reset;
    logic          en;
    logic [2:0]    ctrl;
    logic [AW-1:0] amt;
    logic [N-1:0]  d;
    logic          sin;
    logic [N-1:0]  q;
    logic          sout;
    logic          sout_valid;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    univ_shift_reg_ext #(
        .N (N)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .en         (en),
        .ctrl       (ctrl),
        .amt        (amt),
        .d          (d),
        .sin        (sin),
        .q          (q),
        .sout       (sout),
        .sout_valid (sout_valid),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one IDLE command for a single edge, then drop en.
    task automatic do_op(input logic [2:0] op, input logic [AW-1:0] a, input logic [N-1:0] dv,
                         input logic s);
        en   = 1'b1;
        ctrl = op;
        amt  = a;
        d    = dv;
        sin  = s;
        step();
        en   = 1'b0;
        ctrl = HOLD;
        amt  = '0;
    endtask

    // Called in the first SER cycle; checks the stream of dv and the done pulse afterwards.
    task automatic run_ser(input string tag, input logic [N-1:0] dv, input logic [N-1:0] pat,
                           input bit noise);
        for (int k = 0; k < N; k++) begin
            sin = pat[k];
            if (noise) begin
                en   = (k != N - 1);
                ctrl = LOAD;
                d    = 8'hFF;
                amt  = 3'd2;
            end else begin
                en = 1'b0;
            end
            check_eq($sformatf("%s_valid%0d", tag, k), {31'd0, sout_valid}, 32'd1);
            check_eq($sformatf("%s_busy%0d", tag, k), {31'd0, busy}, 32'd1);
            check_eq($sformatf("%s_sout%0d", tag, k), {31'd0, sout}, {31'd0, dv[k]});
            check_eq($sformatf("%s_done%0d", tag, k), {31'd0, done}, 32'd0);
            step();
        end
        en   = 1'b0;
        ctrl = HOLD;
        amt  = '0;
        check_eq({tag, "_done"}, {31'd0, done}, 32'd1);
        check_eq({tag, "_idle"}, {31'd0, busy}, 32'd0);
        check_eq({tag, "_q"}, {24'd0, q}, {24'd0, pat});
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        ctrl  = HOLD;
        amt   = '0;
        d     = '0;
        sin   = 1'b0;
        step();
        step();
        check_eq("rst_q", {24'd0, q}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_valid", {31'd0, sout_valid}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_sout", {31'd0, sout}, 32'd0);
        reset = 1'b1;
        step();

        do_op(LOAD, 3'd0, 8'hA5, 1'b0);
        check_eq("load_a5", {24'd0, q}, 32'hA5);
        // Asynchronous reset between edges.
        #2 reset = 1'b0;
        #1;
        check_eq("async_rst_q", {24'd0, q}, 32'd0);
        check_eq("async_rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        step();

        do_op(LOAD, 3'd0, 8'h81, 1'b0);
        do_op(SHL, 3'd3, 8'h00, 1'b1);
        check_eq("shl3", {24'd0, q}, 32'h0F);
        do_op(LOAD, 3'd0, 8'h81, 1'b0);
        do_op(SHR, 3'd3, 8'h00, 1'b0);
        check_eq("shr3", {24'd0, q}, 32'h10);
        do_op(LOAD, 3'd0, 8'h81, 1'b0);
        do_op(SHL, 3'd0, 8'h00, 1'b1);
        check_eq("shl0", {24'd0, q}, 32'h81);
        do_op(ROTR, 3'd0, 8'h00, 1'b1);
        check_eq("rotr0", {24'd0, q}, 32'h81);
        do_op(ASR, 3'd0, 8'h00, 1'b0);
        check_eq("asr0", {24'd0, q}, 32'h81);
        do_op(ROTL, 3'd1, 8'h00, 1'b0);
        check_eq("rotl1", {24'd0, q}, 32'h03);
        do_op(LOAD, 3'd0, 8'h81, 1'b0);
        do_op(ROTR, 3'd1, 8'h00, 1'b0);
        check_eq("rotr1", {24'd0, q}, 32'hC0);
        do_op(LOAD, 3'd0, 8'h81, 1'b0);
        do_op(ASR, 3'd2, 8'h00, 1'b0);
        check_eq("asr_neg", {24'd0, q}, 32'hE0);
        do_op(LOAD, 3'd0, 8'h40, 1'b1);
        do_op(ASR, 3'd2, 8'h00, 1'b1);
        check_eq("asr_pos", {24'd0, q}, 32'h10);
        do_op(HOLD, 3'd2, 8'hFF, 1'b1);
        check_eq("hold", {24'd0, q}, 32'h10);
        // en low: LOAD must not take effect.
        ctrl = LOAD;
        d    = 8'hFF;
        step();
        check_eq("en_low_hold", {24'd0, q}, 32'h10);
        ctrl = HOLD;

        // SERIALIZE 0xB4, sin sampled 1,0,1,1,0,0,1,0; LOAD requests during SER ignored.
        do_op(SER, 3'd0, 8'hB4, 1'b0);
        run_ser("ser1", 8'hB4, 8'h4D, 1'b1);
        step();
        check_eq("ser1_done_once", {31'd0, done}, 32'd0);
        check_eq("ser1_q_hold", {24'd0, q}, 32'h4D);

        // Back-to-back: second SERIALIZE issued in the done cycle.
        do_op(SER, 3'd0, 8'h5A, 1'b0);
        run_ser("ser2", 8'h5A, 8'h00, 1'b0);
        do_op(SER, 3'd0, 8'hC3, 1'b0);
        check_eq("b2b_done_clr", {31'd0, done}, 32'd0);
        run_ser("ser3", 8'hC3, 8'hF1, 1'b0);

        // Abort during the 4th SER cycle.
        step();
        do_op(SER, 3'd0, 8'hB4, 1'b1);
        step();
        step();
        step();
        check_eq("abort_busy_pre", {31'd0, busy}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check_eq("abort_q", {24'd0, q}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        check_eq("abort_valid", {31'd0, sout_valid}, 32'd0);
        step();
        check_eq("abort_done_rst", {31'd0, done}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq($sformatf("abort_nodone%0d", i), {30'd0, busy, done}, 32'd0);
        end
        do_op(LOAD, 3'd0, 8'h3C, 1'b0);
        check_eq("post_abort_load", {24'd0, q}, 32'h3C);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
